// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory-bus arbiter: FSM states, master ids and
// the request record carried by the holding slots and the bus register.
package cpu_bus_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      M_I = 1'b0,
      M_D = 1'b1
   } master_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_req_t;

   // Fetches are always full-word reads.
   function automatic bus_req_t fetch_req(input logic [31:0] addr);
      fetch_req = '{addr: addr, write: 1'b0, be: 4'hF, wdata: 32'd0};
   endfunction

endpackage

// File: rtl/cpu_bus_req_slot.sv
// One-entry holding register for a master request awaiting the bus.
module cpu_bus_req_slot
   import cpu_bus_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     i_load,
   input  logic     i_clear,
   input  bus_req_t i_req,
   output logic     o_valid,
   output bus_req_t o_req
);

   logic     r_valid;
   bus_req_t r_req;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_req   <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_req   <= i_req;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_req   = r_req;

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the external memory bus between the fetch (cpui) and data (cpud)
// ports, with alternating priority and a response timeout.
// IDLE: bus free | BUSY_I: fetch owns bus | BUSY_D: data owns bus
module cpu_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERROR_RDATA    = 32'hDEADBEEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpui_request,
   input  logic [31:0] cpui_addr,
   output logic [31:0] cpui_rdata,
   output logic        cpui_ack,
   input  logic        cpud_request,
   input  logic [31:0] cpud_addr,
   input  logic        cpud_write,
   input  logic [3:0]  cpud_byte_enable,
   input  logic [31:0] cpud_wdata,
   output logic [31:0] cpud_rdata,
   output logic        cpud_ack,
   output logic        mem_request,
   output logic [31:0] mem_addr,
   output logic        mem_write,
   output logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_error,
   output logic        protocol_error
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t       r_state;
   master_t          r_last_grant;
   logic [CNT_W-1:0] r_count;
   bus_req_t         r_mem;
   logic             r_mem_request;
   logic             r_protocol_error;

   logic     w_slot_i_valid, w_slot_d_valid;
   bus_req_t w_slot_i_req, w_slot_d_req;
   bus_req_t w_req_i, w_req_d, w_req_d_new;
   logic     w_busy_i, w_busy_d, w_expire, w_done, w_timeout, w_free;
   logic     w_i_ok, w_d_ok, w_i_avail, w_d_avail, w_grant_i, w_grant_d;

   assign w_busy_i  = (r_state == BUSY_I);
   assign w_busy_d  = (r_state == BUSY_D);
   assign w_expire  = (w_busy_i || w_busy_d) && (r_count >= TIMEOUT_CNT);
   assign w_done    = (w_busy_i || w_busy_d) && (mem_ack || w_expire);
   assign w_timeout = w_done && !mem_ack;
   assign w_free    = (r_state == IDLE) || w_done;

   // A master may not re-request while its slot is full or it owns the bus.
   assign w_i_ok = cpui_request && !w_slot_i_valid && !w_busy_i;
   assign w_d_ok = cpud_request && !w_slot_d_valid && !w_busy_d;

   assign w_req_d_new = '{addr: cpud_addr, write: cpud_write,
                          be: cpud_byte_enable, wdata: cpud_wdata};
   assign w_req_i = w_slot_i_valid ? w_slot_i_req : fetch_req(cpui_addr);
   assign w_req_d = w_slot_d_valid ? w_slot_d_req : w_req_d_new;

   // Fresh requests bypass their slot straight into the grant decision.
   assign w_i_avail = w_slot_i_valid || w_i_ok;
   assign w_d_avail = w_slot_d_valid || w_d_ok;
   assign w_grant_d = w_free && w_d_avail && (!w_i_avail || (r_last_grant == M_I));
   assign w_grant_i = w_free && w_i_avail && !w_grant_d;

   cpu_bus_req_slot u_slot_i (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_i_ok && !w_grant_i),
      .i_clear (w_grant_i),
      .i_req   (fetch_req(cpui_addr)),
      .o_valid (w_slot_i_valid),
      .o_req   (w_slot_i_req)
   );

   cpu_bus_req_slot u_slot_d (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_d_ok && !w_grant_d),
      .i_clear (w_grant_d),
      .i_req   (w_req_d_new),
      .o_valid (w_slot_d_valid),
      .o_req   (w_slot_d_req)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state          <= IDLE;
         r_last_grant     <= M_I;
         r_count          <= '0;
         r_mem            <= '0;
         r_mem_request    <= 1'b0;
         r_protocol_error <= 1'b0;
      end else begin
         r_mem_request <= 1'b0;
         if ((cpui_request && !w_i_ok) || (cpud_request && !w_d_ok))
            r_protocol_error <= 1'b1;
         if (w_grant_d) begin
            r_mem         <= w_req_d;
            r_mem_request <= 1'b1;
            r_state       <= BUSY_D;
            r_last_grant  <= M_D;
            r_count       <= '0;
         end else if (w_grant_i) begin
            r_mem         <= w_req_i;
            r_mem_request <= 1'b1;
            r_state       <= BUSY_I;
            r_last_grant  <= M_I;
            r_count       <= '0;
         end else if (w_done) begin
            r_state <= IDLE;
         end else if ((w_busy_i || w_busy_d) && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign cpui_ack   = w_busy_i && w_done;
   assign cpud_ack   = w_busy_d && w_done;
   assign cpui_rdata = (w_busy_i && w_timeout) ? ERROR_RDATA : mem_rdata;
   assign cpud_rdata = (w_busy_d && w_timeout) ? ERROR_RDATA : mem_rdata;
   assign bus_error  = w_timeout;

   assign mem_request     = r_mem_request;
   assign mem_addr        = r_mem.addr;
   assign mem_write       = r_mem.write;
   assign mem_byte_enable = r_mem.be;
   assign mem_wdata       = r_mem.wdata;
   assign protocol_error  = r_protocol_error;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: bus issues and master acks are
// predicted at stimulus time and matched by a negedge monitor.
module tb_cpu_bus_arbiter;
   import cpu_bus_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpui_request = 1'b0;
   logic [31:0] cpui_addr = '0;
   logic [31:0] cpui_rdata;
   logic        cpui_ack;
   logic        cpud_request = 1'b0;
   logic [31:0] cpud_addr = '0;
   logic        cpud_write = 1'b0;
   logic [3:0]  cpud_byte_enable = '0;
   logic [31:0] cpud_wdata = '0;
   logic [31:0] cpud_rdata;
   logic        cpud_ack;
   logic        mem_request;
   logic [31:0] mem_addr;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        bus_error;
   logic        protocol_error;

   cpu_bus_arbiter #(.TIMEOUT_CYCLES(4), .ERROR_RDATA(32'hDEADBEEF)) dut (
      .clock(clock), .reset(reset),
      .cpui_request(cpui_request), .cpui_addr(cpui_addr),
      .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
      .cpud_request(cpud_request), .cpud_addr(cpud_addr), .cpud_write(cpud_write),
      .cpud_byte_enable(cpud_byte_enable), .cpud_wdata(cpud_wdata),
      .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack),
      .mem_request(mem_request), .mem_addr(mem_addr), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .bus_error(bus_error), .protocol_error(protocol_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        berr;
   } ack_exp_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_req_cyc = -1;
   int last_ack_cyc = -1;
   int last_berr_cyc = -1;

   bus_req_t exp_mem[$];
   ack_exp_t exp_ack[$];
   bus_req_t m_e;
   ack_exp_t a_e;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (mem_request) begin
         last_req_cyc = cyc;
         checks++;
         if (exp_mem.size() == 0) begin
            errors++;
            $display("FAIL mem_issue: unexpected mem_request addr=%h at cycle %0d", mem_addr, cyc);
         end else begin
            m_e = exp_mem.pop_front();
            if ({mem_addr, mem_write, mem_byte_enable, mem_wdata} !== m_e) begin
               errors++;
               $display("FAIL mem_issue: got addr=%h wr=%b be=%h wd=%h, want addr=%h wr=%b be=%h wd=%h",
                        mem_addr, mem_write, mem_byte_enable, mem_wdata,
                        m_e.addr, m_e.write, m_e.be, m_e.wdata);
            end
         end
      end
      if (cpui_ack || cpud_ack) begin
         last_ack_cyc = cyc;
         if (bus_error) last_berr_cyc = cyc;
         checks++;
         if (exp_ack.size() == 0) begin
            errors++;
            $display("FAIL master_ack: unexpected ack i=%b d=%b at cycle %0d", cpui_ack, cpud_ack, cyc);
         end else begin
            a_e = exp_ack.pop_front();
            if (cpud_ack !== a_e.is_d || cpui_ack !== !a_e.is_d ||
                (a_e.is_d ? cpud_rdata : cpui_rdata) !== a_e.rdata || bus_error !== a_e.berr) begin
               errors++;
               $display("FAIL master_ack: got i=%b d=%b irdata=%h drdata=%h berr=%b, want d=%b rdata=%h berr=%b",
                        cpui_ack, cpud_ack, cpui_rdata, cpud_rdata, bus_error,
                        a_e.is_d, a_e.rdata, a_e.berr);
            end
         end
      end else if (bus_error) begin
         last_berr_cyc = cyc;
         checks++;
         errors++;
         $display("FAIL bus_error_alone: bus_error without ack at cycle %0d", cyc);
      end
   end

   function automatic bus_req_t mk(input logic [31:0] a, input logic w,
                                   input logic [3:0] be, input logic [31:0] wd);
      mk = '{addr: a, write: w, be: be, wdata: wd};
   endfunction

   function automatic ack_exp_t mka(input logic d, input logic [31:0] r, input logic b);
      mka = '{is_d: d, rdata: r, berr: b};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_ack(input logic [31:0] d);
      mem_ack = 1'b1;
      mem_rdata = d;
      tick();
      mem_ack = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cpui_request = 1'b0;
      cpud_request = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      tick();
      tick();
      reset = 1'b0;
      last_req_cyc = -1;
      last_ack_cyc = -1;
      last_berr_cyc = -1;
   endtask

   task automatic store_req(input logic [31:0] a, input logic w, input logic [3:0] be,
                            input logic [31:0] wd);
      cpud_request = 1'b1;
      cpud_addr = a;
      cpud_write = w;
      cpud_byte_enable = be;
      cpud_wdata = wd;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      @(negedge clock);
      checks++;
      if ({mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
           cpui_ack, cpud_ack, bus_error, protocol_error} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b addr=%h wr=%b be=%h wd=%h iack=%b dack=%b berr=%b perr=%b, want all 0",
                  mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
                  cpui_ack, cpud_ack, bus_error, protocol_error);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single_fetch();
      int t0, ta;
      do_reset();
      cpui_request = 1'b1;
      cpui_addr = 32'h100;
      exp_mem.push_back(mk(32'h100, 1'b0, 4'hF, 32'h0));
      t0 = cyc;
      tick();
      cpui_request = 1'b0;
      tick();
      tick();
      tick();
      ta = cyc;
      exp_ack.push_back(mka(1'b0, 32'h12345678, 1'b0));
      drive_ack(32'h12345678);
      checks++;
      if (last_req_cyc != t0 + 1) begin
         errors++;
         $display("FAIL fetch_issue_latency: mem_request at %0d, want %0d", last_req_cyc, t0 + 1);
      end
      checks++;
      if (last_ack_cyc != ta) begin
         errors++;
         $display("FAIL fetch_ack_same_cycle: ack at %0d, want %0d", last_ack_cyc, ta);
      end
   endtask

   task automatic issue_pair(input logic d_first);
      int ta;
      bus_req_t rq_i, rq_d;
      rq_i = mk(32'h200, 1'b0, 4'hF, 32'h0);
      rq_d = mk(32'h300, 1'b1, 4'h3, 32'hAABBCCDD);
      cpui_request = 1'b1;
      cpui_addr = 32'h200;
      store_req(32'h300, 1'b1, 4'h3, 32'hAABBCCDD);
      exp_mem.push_back(d_first ? rq_d : rq_i);
      exp_mem.push_back(d_first ? rq_i : rq_d);
      exp_ack.push_back(mka(d_first, 32'h000000A1, 1'b0));
      exp_ack.push_back(mka(!d_first, 32'h000000B2, 1'b0));
      tick();
      cpui_request = 1'b0;
      cpud_request = 1'b0;
      tick();
      ta = cyc;
      drive_ack(32'h000000A1);
      tick();
      checks++;
      if (last_req_cyc != ta + 1) begin
         errors++;
         $display("FAIL contended_loser_issue: mem_request at %0d, want %0d", last_req_cyc, ta + 1);
      end
      drive_ack(32'h000000B2);
   endtask

   task automatic test_contention();
      do_reset();
      issue_pair(1'b1);
      issue_pair(1'b1);
      store_req(32'h340, 1'b1, 4'hF, 32'h01020304);
      exp_mem.push_back(mk(32'h340, 1'b1, 4'hF, 32'h01020304));
      exp_ack.push_back(mka(1'b1, 32'h0000C3C3, 1'b0));
      tick();
      cpud_request = 1'b0;
      tick();
      drive_ack(32'h0000C3C3);
      issue_pair(1'b0);
   endtask

   task automatic test_back_to_back();
      int ta;
      do_reset();
      cpui_request = 1'b1;
      cpui_addr = 32'h400;
      exp_mem.push_back(mk(32'h400, 1'b0, 4'hF, 32'h0));
      tick();
      cpui_request = 1'b0;
      store_req(32'h500, 1'b0, 4'hF, 32'h0);
      exp_mem.push_back(mk(32'h500, 1'b0, 4'hF, 32'h0));
      tick();
      cpud_request = 1'b0;
      ta = cyc;
      exp_ack.push_back(mka(1'b0, 32'h55, 1'b0));
      drive_ack(32'h55);
      tick();
      checks++;
      if (last_req_cyc != ta + 1) begin
         errors++;
         $display("FAIL held_data_issue: mem_request at %0d, want %0d", last_req_cyc, ta + 1);
      end
      exp_ack.push_back(mka(1'b1, 32'h66, 1'b0));
      drive_ack(32'h66);
      checks++;
      if (last_berr_cyc != -1) begin
         errors++;
         $display("FAIL held_no_bus_error: bus_error at %0d, want none", last_berr_cyc);
      end
   endtask

   task automatic test_timeout();
      int t0;
      do_reset();
      store_req(32'h600, 1'b1, 4'hF, 32'h1234);
      exp_mem.push_back(mk(32'h600, 1'b1, 4'hF, 32'h1234));
      exp_ack.push_back(mka(1'b1, 32'hDEADBEEF, 1'b1));
      t0 = cyc;
      tick();
      cpud_request = 1'b0;
      repeat (5) tick();
      checks++;
      if (last_ack_cyc != t0 + 5 || last_berr_cyc != t0 + 5) begin
         errors++;
         $display("FAIL timeout_ack: ack at %0d berr at %0d, want %0d", last_ack_cyc, last_berr_cyc, t0 + 5);
      end
      mem_ack = 1'b1;
      mem_rdata = 32'h0BAD0BAD;
      @(negedge clock);
      checks++;
      if (cpud_ack !== 1'b0 || cpui_ack !== 1'b0 || bus_error !== 1'b0) begin
         errors++;
         $display("FAIL late_ack_ignored: iack=%b dack=%b berr=%b, want 0", cpui_ack, cpud_ack, bus_error);
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = '0;
      last_berr_cyc = -1;
      store_req(32'h610, 1'b0, 4'hF, 32'h0);
      exp_mem.push_back(mk(32'h610, 1'b0, 4'hF, 32'h0));
      exp_ack.push_back(mka(1'b1, 32'h77, 1'b0));
      tick();
      cpud_request = 1'b0;
      repeat (4) tick();
      drive_ack(32'h77);
      checks++;
      if (last_berr_cyc != -1) begin
         errors++;
         $display("FAIL ack_beats_expiry: bus_error at %0d, want none", last_berr_cyc);
      end
   endtask

   task automatic test_protocol_error();
      int t0;
      do_reset();
      @(negedge clock);
      checks++;
      if (protocol_error !== 1'b0) begin
         errors++;
         $display("FAIL perr_initial: got %b, want 0", protocol_error);
      end
      tick();
      store_req(32'h700, 1'b1, 4'hF, 32'hCAFE);
      exp_mem.push_back(mk(32'h700, 1'b1, 4'hF, 32'hCAFE));
      t0 = cyc;
      tick();
      store_req(32'h7FF, 1'b1, 4'hF, 32'hBAD);
      tick();
      cpud_request = 1'b0;
      @(negedge clock);
      checks++;
      if (protocol_error !== 1'b1) begin
         errors++;
         $display("FAIL perr_set: got %b, want 1", protocol_error);
      end
      tick();
      exp_ack.push_back(mka(1'b1, 32'h88, 1'b0));
      drive_ack(32'h88);
      repeat (3) tick();
      checks++;
      if (last_req_cyc != t0 + 1) begin
         errors++;
         $display("FAIL no_second_issue: last mem_request at %0d, want %0d", last_req_cyc, t0 + 1);
      end
      checks++;
      if (protocol_error !== 1'b1) begin
         errors++;
         $display("FAIL perr_sticky: got %b, want 1", protocol_error);
      end
      do_reset();
      @(negedge clock);
      checks++;
      if (protocol_error !== 1'b0) begin
         errors++;
         $display("FAIL perr_cleared: got %b, want 0", protocol_error);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      store_req(32'h800, 1'b1, 4'h5, 32'h5A5A5A5A);
      exp_mem.push_back(mk(32'h800, 1'b1, 4'h5, 32'h5A5A5A5A));
      tick();
      cpud_request = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata, cpui_ack, cpud_ack,
           cpui_rdata, cpud_rdata, bus_error, protocol_error} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: req=%b addr=%h wr=%b be=%h wd=%h iack=%b dack=%b berr=%b perr=%b, want all 0",
                  mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata,
                  cpui_ack, cpud_ack, bus_error, protocol_error);
      end
      tick();
      mem_ack = 1'b1;
      mem_rdata = 32'h99;
      @(negedge clock);
      checks++;
      if (cpud_ack !== 1'b0 || cpui_ack !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_ack_discarded: iack=%b dack=%b, want 0", cpui_ack, cpud_ack);
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = '0;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_contention();
      test_back_to_back();
      test_timeout();
      test_protocol_error();
      test_reset_mid();
      repeat (3) tick();
      checks++;
      if (exp_mem.size() != 0 || exp_ack.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d issues and %0d acks outstanding, want 0",
                  exp_mem.size(), exp_ack.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Two-master arbiter that shares the single external memory bus between the CPU instruction-fetch port (cpui) and the CPU data port (cpud, driven by cpu_memif). Each master issues one-cycle request pulses with at most one transaction outstanding. The arbiter holds each request in a one-entry slot, grants the bus to one master at a time, and routes ack/rdata back to the owner. It also enforces a response timeout so a dead target cannot hang the pipeline.

## Interface
- TIMEOUT_CYCLES, 255: cycles from mem_request to forced completion; valid range 1..65535.
- ERROR_RDATA, 32'hDEADBEEF: rdata returned on a timed-out read.

Reset reset, synchronous, active-high; clock clock.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cpui_request  in  1  fetch request pulse (always read, full word)
- cpui_addr  in  32  fetch address
- cpui_rdata  out  32  fetch data
- cpui_ack  out  1  fetch completion pulse
- cpud_request  in  1  data request pulse
- cpud_addr  in  32  data address
- cpud_write  in  1  1 = write
- cpud_byte_enable  in  4  write byte lanes
- cpud_wdata  in  32  write data
- cpud_rdata  out  32  read data
- cpud_ack  out  1  data completion pulse
- mem_request  out  1  bus request pulse, registered
- mem_addr  out  32  bus address, registered
- mem_write  out  1  bus write, registered
- mem_byte_enable  out  4  registered; 4'b1111 for fetches
- mem_wdata  out  32  registered; 0 for fetches
- mem_rdata  in  32  bus read data
- mem_ack  in  1  bus completion pulse
- bus_error  out  1  one-cycle pulse on timeout completion
- protocol_error  out  1  sticky; set when a master requests while its slot is full; cleared only by reset

## Operation
- Slots: pend_i {addr}, pend_d {addr, write, be, wdata}. A request pulse loads its slot and sets the valid bit.
- FSM: IDLE, BUSY_I, BUSY_D.
- IDLE: if any slot is valid, or any request arrives this cycle (requests bypass into the grant decision), grant and issue. On a grant, mem_* are loaded from the slot/bypass, mem_request pulses next cycle, the granted slot clears, and the counter loads 0.
- Priority when both are pending: the master not granted last wins (last_grant flop, reset = I, so D wins first). A single pending master always wins.
- BUSY_x: on mem_ack, pulse x_ack with x_rdata = mem_rdata in the same cycle (combinational route) and go to IDLE. The grant decision for the next transaction is made in that same cycle, so back-to-back transactions have mem_request one cycle after mem_ack.
- Timeout: the counter increments each BUSY cycle. When it reaches TIMEOUT_CYCLES without mem_ack, pulse x_ack with rdata = ERROR_RDATA, pulse bus_error, and take the IDLE transition. If mem_ack and expiry coincide, mem_ack wins and there is no bus_error.
- mem_ack seen in IDLE (late or spurious) is discarded.
- Request while its own slot is valid, or while that master owns the bus: the request is ignored and protocol_error is set.
- Unselected ack outputs are 0. cpui_rdata and cpud_rdata show mem_rdata when idle; consumers qualify on ack.

## Timing
- Reset values: state IDLE, slots invalid, last_grant = I, counter 0. mem_request 0, mem_addr 0, mem_write 0, mem_byte_enable 0, mem_wdata 0. cpui_ack, cpud_ack, bus_error and protocol_error are all 0.
- Uncontended latency: request at cycle N gives mem_request at N+1. mem_ack at M gives master ack at M.
- A contended loser issues at M+1 after the winner's mem_ack at M.
- Reset mid-transaction: everything returns to reset values the next cycle. The outstanding master receives no ack, and a subsequent mem_ack is discarded.
- The counter is 16 bits wide and saturates; it never wraps.

## Structure
- cpu_bus_pkg: arb_state_t enum {IDLE, BUSY_I, BUSY_D}, master_t enum {M_I, M_D}, and a bus_req_t struct {addr, write, be, wdata} shared by the slots and the mem_* register.
- One sub-module, cpu_bus_req_slot (one-entry holding register with valid/load/clear), instantiated twice.

## Test plan
- Single fetch: cpui_request at addr 0x100. Expect mem_request next cycle with be=4'hF and write=0. mem_ack with rdata 0x12345678 3 cycles later → cpui_ack in the same cycle with rdata 0x12345678.
- Simultaneous fetch 0x200 and store 0x300/0xAABBCCDD/be=4'h3 from reset. Expect the store issued first, the fetch issued in the cycle after the store's mem_ack, and last_grant toggling on a repeat.
- Data request arriving while the fetch is BUSY: it is held in its slot and issued exactly 1 cycle after the fetch's mem_ack; no bus_error.
- TIMEOUT_CYCLES=4 and no mem_ack: cpud_ack with rdata 0xDEADBEEF and a bus_error pulse 4 cycles after mem_request. A mem_ack one cycle later is ignored.
- Second cpud_request while data owns the bus: no second mem_request is issued and protocol_error stays 1 until reset.
- Reset asserted in BUSY_D: the next cycle is IDLE with all outputs 0. A following mem_ack produces no cpud_ack.
